// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit example ALU: opcode encoding and the
// fixed result returned when dividing by zero.
package alu_pkg;

  // 4-bit opcode carried on ui_in[7:4]; 13..15 are reserved and yield zero
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NOTA = 4'd6,
    OP_NOTB = 4'd7,
    OP_SQA  = 4'd8,
    OP_SQB  = 4'd9,
    OP_LT   = 4'd10,
    OP_EQ   = 4'd11,
    OP_GT   = 4'd12
  } op_e;

  // Division by zero saturates to all ones rather than producing X
  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  // Result value used for the reserved opcodes
  localparam logic [7:0] RESERVED_RESULT = 8'h00;

endpackage : alu_pkg

// File: rtl/alu8_comb.sv
// Purely combinational 8-bit ALU core. All arithmetic is unsigned and keeps
// only the low 8 bits; every opcode, including reserved ones, gives a defined
// result.
module alu8_comb
  import alu_pkg::*;
(
  input  logic [3:0] sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] r
);

  // Select the operation; 8-bit wide expressions naturally truncate mod 256
  always_comb begin
    r = RESERVED_RESULT;
    case (op_e'(sel))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_DIV:  r = (b == 8'd0) ? DIV0_RESULT : (a / b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      OP_SQA:  r = a * a;
      OP_SQB:  r = b * b;
      OP_LT:   r = (a < b)  ? 8'h01 : 8'h00;
      OP_EQ:   r = (a == b) ? 8'h01 : 8'h00;
      OP_GT:   r = (a > b)  ? 8'h01 : 8'h00;
      default: r = RESERVED_RESULT;
    endcase
  end

endmodule : alu8_comb

// File: rtl/tt_um_example_alu.sv
// TinyTapeout-style wrapper around the 8-bit ALU. ui_in supplies the opcode
// and a 4-bit operand A, uio_in supplies operand B, and the result is held
// in a register driven on uo_out. The uio bank is used purely as inputs.
module tt_um_example_alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] sel;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] next_result;
  logic [7:0] result_q;

  assign sel  = ui_in[7:4];
  assign op_a = {4'b0000, ui_in[3:0]};
  assign op_b = uio_in;

  alu8_comb u_alu (
    .sel (sel),
    .a   (op_a),
    .b   (op_b),
    .r   (next_result)
  );

  // Result register: cleared asynchronously, loads only on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 8'h00;
    end else if (ena) begin
      result_q <= next_result;
    end
  end

  assign uo_out  = result_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule : tt_um_example_alu

// File: tb/tb_tt_um_example_alu.sv
// Self-checking bench for tt_um_example_alu: directed vector table, hand
// sequences for reset/enable behaviour, and randomized vectors compared
// against an arithmetic reference model.
module tb_tt_um_example_alu;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] a;
    logic [7:0] b;
    logic [7:0] expected;
    string      name;
  } vec_t;

  vec_t vecs[$];

  tt_um_example_alu dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the operation table with plain integers
  function automatic logic [7:0] ref_alu(input int sel, input int a, input int b);
    int v;
    case (sel)
      0:  v = (a + b) % 256;
      1:  v = (a - b + 256) % 256;
      2:  v = (a * b) % 256;
      3:  v = (b == 0) ? 255 : (a / b);
      4:  v = a & b;
      5:  v = a | b;
      6:  v = 255 - a;
      7:  v = 255 - b;
      8:  v = (a * a) % 256;
      9:  v = (b * b) % 256;
      10: v = (a < b) ? 1 : 0;
      11: v = (a == b) ? 1 : 0;
      12: v = (a > b) ? 1 : 0;
      default: v = 0;
    endcase
    return v[7:0];
  endfunction

  task automatic applyStimulus(input logic [3:0] sel, input logic [3:0] a,
                               input logic [7:0] b, input logic en);
    ui_in  = {sel, a};
    uio_in = b;
    ena    = en;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expected);
    tests_run++;
    if (uo_out !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: uo_out=%02h expected=%02h", name, uo_out, expected);
    end
  endtask

  task automatic checkTieOffs(input string name);
    tests_run++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL %s: uio_oe=%02h uio_out=%02h expected=00/00",
               name, uio_oe, uio_out);
    end
  endtask

  // Apply one enabled vector at the falling edge and check after the rising edge
  task automatic runVector(input vec_t v);
    @(negedge clk);
    applyStimulus(v.sel, v.a, v.b, 1'b1);
    @(posedge clk);
    #1;
    checkOutput(v.name, v.expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] held;
    logic [7:0] model_q;
    logic [3:0] rs;
    logic [3:0] ra;
    logic [7:0] rb;
    logic       ren;

    // Directed vectors: A=F, B=9E opcode sweep, then boundary cases
    vecs.push_back('{4'd0,  4'hF, 8'h9E, 8'hAD, "sweep_add"});
    vecs.push_back('{4'd1,  4'hF, 8'h9E, 8'h71, "sweep_sub"});
    vecs.push_back('{4'd2,  4'hF, 8'h9E, 8'h42, "sweep_mul"});
    vecs.push_back('{4'd3,  4'hF, 8'h9E, 8'h00, "sweep_div"});
    vecs.push_back('{4'd4,  4'hF, 8'h9E, 8'h0E, "sweep_and"});
    vecs.push_back('{4'd5,  4'hF, 8'h9E, 8'h9F, "sweep_or"});
    vecs.push_back('{4'd6,  4'hF, 8'h9E, 8'hF0, "sweep_nota"});
    vecs.push_back('{4'd7,  4'hF, 8'h9E, 8'h61, "sweep_notb"});
    vecs.push_back('{4'd8,  4'hF, 8'h9E, 8'hE1, "sweep_sqa"});
    vecs.push_back('{4'd9,  4'hF, 8'h9E, 8'h84, "sweep_sqb"});
    vecs.push_back('{4'd10, 4'hF, 8'h9E, 8'h01, "sweep_lt"});
    vecs.push_back('{4'd11, 4'hF, 8'h9E, 8'h00, "sweep_eq"});
    vecs.push_back('{4'd12, 4'hF, 8'h9E, 8'h00, "sweep_gt"});
    vecs.push_back('{4'd3,  4'h9, 8'h00, 8'hFF, "div_by_zero"});
    vecs.push_back('{4'd3,  4'hF, 8'h02, 8'h07, "div_floor"});
    vecs.push_back('{4'd13, 4'hF, 8'h9E, 8'h00, "reserved_13"});
    vecs.push_back('{4'd14, 4'h9, 8'hFF, 8'h00, "reserved_14"});
    vecs.push_back('{4'd15, 4'h1, 8'h01, 8'h00, "reserved_15"});
    vecs.push_back('{4'd10, 4'h5, 8'h05, 8'h00, "lt_equal"});
    vecs.push_back('{4'd11, 4'h5, 8'h05, 8'h01, "eq_equal"});
    vecs.push_back('{4'd12, 4'h5, 8'h05, 8'h00, "gt_equal"});
    vecs.push_back('{4'd1,  4'h0, 8'hFF, 8'h01, "sub_wrap"});
    vecs.push_back('{4'd12, 4'h0, 8'hFF, 8'h00, "gt_zero_max"});
    vecs.push_back('{4'd12, 4'h6, 8'h05, 8'h01, "gt_true"});
    vecs.push_back('{4'd0,  4'hF, 8'hFF, 8'h0E, "add_wrap"});

    // Reset asserted with live inputs: output must be zero before any edge
    rst = 1'b1;
    applyStimulus(4'd0, 4'hF, 8'h9E, 1'b1);
    #3;
    checkOutput("reset_immediate", 8'h00);
    checkTieOffs("tieoff_reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held_across_edges", 8'h00);

    // Release reset; value persists until first enabled edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_persist_before_edge", 8'h00);
    @(posedge clk);
    #1;
    checkOutput("first_result_latency", 8'hAD);

    foreach (vecs[i]) runVector(vecs[i]);
    checkTieOffs("tieoff_after_table");

    // Enable low: inputs wander, output must hold
    @(negedge clk);
    applyStimulus(4'd0, 4'h1, 8'h02, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("hold_setup", 8'h03);
    held = uo_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(4'($urandom_range(0, 12)), 4'($urandom), 8'($urandom), 1'b0);
      @(posedge clk);
      #1;
      checkOutput("hold_ena_low", held);
    end
    @(negedge clk);
    applyStimulus(4'd2, 4'h3, 8'h07, 1'b1);
    #1;
    checkOutput("hold_until_edge", 8'h03);
    @(posedge clk);
    #1;
    checkOutput("ena_resume", 8'h15);

    // Asynchronous reset mid-cycle while output is non-zero
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_midcycle", 8'h00);
    checkTieOffs("tieoff_async_reset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd5, 4'hA, 8'h50, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("post_reset_ena_low", 8'h00);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_enabled", 8'h5A);

    // Randomized vectors with random enable against the reference model
    model_q = uo_out;
    for (int i = 0; i < 300; i++) begin
      rs  = 4'($urandom);
      ra  = 4'($urandom);
      rb  = 8'($urandom);
      ren = ($urandom_range(0, 3) != 0);
      if (i % 16 == 0) rb = 8'h00;
      @(negedge clk);
      applyStimulus(rs, ra, rb, ren);
      if (ren) model_q = ref_alu(int'(rs), int'(ra), int'(rb));
      @(posedge clk);
      #1;
      checkOutput("random", model_q);
    end
    checkTieOffs("tieoff_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_tt_um_example_alu
